// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage:
// loader FSM encodings, header length and default instruction-memory depth.
package mips_pkg;

    localparam int IMEM_SIZE_DEFAULT = 256;
    localparam int HDR_BYTES         = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } load_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: the first accepted byte ends up in bits 31:24.
// word/word_valid are combinational so the caller sees the full word on the 4th accept.
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sr;
    logic [1:0]  count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            count <= '0;
        end else if (clear) begin
            sr    <= '0;
            count <= '0;
        end else if (accept) begin
            sr    <= {sr[15:0], byte_in};
            count <= count + 2'd1;
        end
    end

    // A stalled stream simply leaves sr/count untouched until the next accept.
    assign word       = {sr, byte_in};
    assign word_valid = accept && (count == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, big-endian program into instruction memory and
// holds the fetch stage until the load completes or is rejected.
module imem_loader
    import mips_pkg::*;
#(
    parameter int          IMEM_SIZE = IMEM_SIZE_DEFAULT,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        WE,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam logic [31:0] IMEM_WORDS = 32'(IMEM_SIZE);

    load_state_t state, state_next;
    logic [31:0] word;
    logic        word_valid;
    logic        accept;
    logic        load;
    logic [31:0] word_cnt;
    logic [31:0] word_total;

    assign byte_ready = (state == S_HDR) || (state == S_DATA);
    assign accept     = byte_valid && byte_ready;
    assign load       = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign cpu_hold   = (state == S_HDR) || (state == S_DATA) || (state == S_ERR) || WE;
    assign state_dbg  = state;

    byte_packer u_packer (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (load),
        .accept     (accept),
        .byte_in    (byte_in),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_HDR;
            S_HDR: begin
                if (word_valid) begin
                    if (word == 32'd0)            state_next = S_DONE;
                    else if (word > IMEM_WORDS)   state_next = S_ERR;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid && (word_cnt == word_total - 32'd1)) state_next = S_DONE;
            end
            S_DONE: if (start) state_next = S_HDR;
            S_ERR:  if (start) state_next = S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            WE         <= 1'b0;
            W_Addr     <= BASE_ADDR;
            W_Ins      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            word_total <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == S_DONE);
            err   <= (state_next == S_ERR);
            WE    <= (state == S_DATA) && word_valid;
            if ((state == S_HDR) && word_valid) word_total <= word;
            if ((state == S_DATA) && word_valid) W_Ins <= word;
            // A restart wins over the address bump of a coincident final write.
            if (load) begin
                W_Addr   <= BASE_ADDR;
                word_cnt <= '0;
            end else begin
                if (WE) W_Addr <= W_Addr + 32'd4;
                if ((state == S_DATA) && word_valid) word_cnt <= word_cnt + 32'd1;
            end
        end
    end

endmodule
